// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter that serialises single-beat fetch and data transactions
// onto one memory bus, giving data priority with a bounded fetch starvation window.
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int AW = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ireq_valid,
  input  logic [AW-1:0] ireq_addr,
  output logic          iresp_addr_ok,
  output logic          iresp_data_ok,
  output logic [31:0]   iresp_data,
  input  logic          dreq_valid,
  input  logic [AW-1:0] dreq_addr,
  input  logic [2:0]    dreq_size,
  input  logic [7:0]    dreq_strobe,
  input  logic [63:0]   dreq_data,
  output logic          dresp_addr_ok,
  output logic          dresp_data_ok,
  output logic [63:0]   dresp_data,
  output logic          creq_valid,
  output logic          creq_is_write,
  output logic [AW-1:0] creq_addr,
  output logic [2:0]    creq_size,
  output logic [7:0]    creq_strobe,
  output logic [63:0]   creq_data,
  input  logic          cresp_ready,
  input  logic [63:0]   cresp_data
);

  localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] starve_cnt, starve_cnt_nxt;
  logic          grant_i, grant_d;

  logic          req_write_p1;
  logic [AW-1:0] req_addr_p1;
  logic [2:0]    req_size_p1;
  logic [7:0]    req_strobe_p1;
  logic [63:0]   req_data_p1;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == LIMIT) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    grant_i        = 1'b0;
    grant_d        = 1'b0;
    iresp_addr_ok  = 1'b0;
    iresp_data_ok  = 1'b0;
    iresp_data     = '0;
    dresp_addr_ok  = 1'b0;
    dresp_data_ok  = 1'b0;
    dresp_data     = '0;
    case (state)
      IDLE: begin
        if (ireq_valid && dreq_valid) begin
          if (STARVE_LIMIT != 0 && starve_cnt == LIMIT) grant_i = 1'b1;
          else grant_d = 1'b1;
        end else if (ireq_valid) begin
          grant_i = 1'b1;
        end else if (dreq_valid) begin
          grant_d = 1'b1;
        end
      end
      // A response arriving while reset is held belongs to a dropped transaction.
      GRANT_I: begin
        if (cresp_ready && !reset) begin
          iresp_addr_ok = 1'b1;
          iresp_data_ok = 1'b1;
          iresp_data    = req_addr_p1[2] ? cresp_data[63:32] : cresp_data[31:0];
          state_nxt     = IDLE;
        end
      end
      GRANT_D: begin
        if (cresp_ready && !reset) begin
          dresp_addr_ok = 1'b1;
          dresp_data_ok = 1'b1;
          dresp_data    = cresp_data;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (grant_i) begin
      state_nxt      = GRANT_I;
      starve_cnt_nxt = '0;
    end
    if (grant_d) begin
      state_nxt = GRANT_D;
      if (ireq_valid) starve_cnt_nxt = sat_inc(starve_cnt);
    end
  end

  // ---- request latch stage (p1): winner captured on the grant edge ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      req_write_p1  <= 1'b0;
      req_addr_p1   <= '0;
      req_size_p1   <= '0;
      req_strobe_p1 <= '0;
      req_data_p1   <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
      if (grant_i) begin
        req_write_p1  <= 1'b0;
        req_addr_p1   <= ireq_addr;
        req_size_p1   <= 3'd2;
        req_strobe_p1 <= '0;
        req_data_p1   <= '0;
      end else if (grant_d) begin
        req_write_p1  <= |dreq_strobe;
        req_addr_p1   <= dreq_addr;
        req_size_p1   <= dreq_size;
        req_strobe_p1 <= dreq_strobe;
        req_data_p1   <= dreq_data;
      end
    end
  end

  assign creq_valid    = (state != IDLE);
  assign creq_is_write = creq_valid & req_write_p1;
  assign creq_addr     = creq_valid ? req_addr_p1   : '0;
  assign creq_size     = creq_valid ? req_size_p1   : '0;
  assign creq_strobe   = creq_valid ? req_strobe_p1 : '0;
  assign creq_data     = creq_valid ? req_data_p1   : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: expected transactions are queued in grant
// order and checked when the owner's data_ok fires.
module tb_mem_bus_arbiter;
  localparam int SL = 2;
  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          ireq_valid;
  logic [AW-1:0] ireq_addr;
  logic          iresp_addr_ok, iresp_data_ok;
  logic [31:0]   iresp_data;
  logic          dreq_valid;
  logic [AW-1:0] dreq_addr;
  logic [2:0]    dreq_size;
  logic [7:0]    dreq_strobe;
  logic [63:0]   dreq_data;
  logic          dresp_addr_ok, dresp_data_ok;
  logic [63:0]   dresp_data;
  logic          creq_valid, creq_is_write;
  logic [AW-1:0] creq_addr;
  logic [2:0]    creq_size;
  logic [7:0]    creq_strobe;
  logic [63:0]   creq_data;
  logic          cresp_ready;
  logic [63:0]   cresp_data;

  mem_bus_arbiter #(.STARVE_LIMIT(SL), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .creq_valid(creq_valid), .creq_is_write(creq_is_write), .creq_addr(creq_addr),
    .creq_size(creq_size), .creq_strobe(creq_strobe), .creq_data(creq_data),
    .cresp_ready(cresp_ready), .cresp_data(cresp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_i;
    logic        is_write;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [63:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   i_done = 0;
  int   d_done = 0;

  function automatic exp_t mk_i(input logic [63:0] a, input logic [63:0] rsp);
    exp_t e;
    e.is_i = 1'b1; e.is_write = 1'b0; e.addr = a; e.size = 3'd2;
    e.strobe = 8'h00; e.data = 64'h0;
    e.rdata = a[2] ? {32'h0, rsp[63:32]} : {32'h0, rsp[31:0]};
    return e;
  endfunction

  function automatic exp_t mk_d(input logic [63:0] a, input logic [2:0] sz,
                                input logic [7:0] st, input logic [63:0] d,
                                input logic [63:0] rsp);
    exp_t e;
    e.is_i = 1'b0; e.is_write = (st != 8'h00); e.addr = a; e.size = sz;
    e.strobe = st; e.data = d; e.rdata = rsp;
    return e;
  endfunction

  // Completion monitor: pops the scoreboard whenever a response is handed back.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (!iresp_data_ok && (iresp_addr_ok || iresp_data != 32'h0)) begin
        failures++;
        $display("FAIL idle_iresp got ok=%b data=%h want 0", iresp_addr_ok, iresp_data);
      end
      checks++;
      if (!dresp_data_ok && (dresp_addr_ok || dresp_data != 64'h0)) begin
        failures++;
        $display("FAIL idle_dresp got ok=%b data=%h want 0", dresp_addr_ok, dresp_data);
      end
      if (iresp_data_ok || dresp_data_ok) begin
        checks++;
        if (!creq_valid) begin
          failures++;
          $display("FAIL resp_without_req got creq_valid=0 want 1");
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_resp got i_ok=%b d_ok=%b want none", iresp_data_ok, dresp_data_ok);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (iresp_data_ok !== e.is_i || dresp_data_ok !== !e.is_i) begin
            failures++;
            $display("FAIL owner got i_ok=%b d_ok=%b want is_i=%b", iresp_data_ok, dresp_data_ok, e.is_i);
          end
          checks++;
          if (creq_addr !== e.addr || creq_is_write !== e.is_write || creq_size !== e.size) begin
            failures++;
            $display("FAIL creq_hdr got a=%h w=%b s=%0d want a=%h w=%b s=%0d",
                     creq_addr, creq_is_write, creq_size, e.addr, e.is_write, e.size);
          end
          checks++;
          if (creq_strobe !== e.strobe || creq_data !== e.data) begin
            failures++;
            $display("FAIL creq_payload got st=%h d=%h want st=%h d=%h", creq_strobe, creq_data, e.strobe, e.data);
          end
          checks++;
          if (e.is_i) begin
            if (iresp_data !== e.rdata[31:0] || !iresp_addr_ok) begin
              failures++;
              $display("FAIL iresp_data got %h ok=%b want %h", iresp_data, iresp_addr_ok, e.rdata[31:0]);
            end
            i_done++;
          end else begin
            if (dresp_data !== e.rdata || !dresp_addr_ok) begin
              failures++;
              $display("FAIL dresp_data got %h ok=%b want %h", dresp_data, dresp_addr_ok, e.rdata);
            end
            d_done++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cresp_ready = 1'b1;
    cresp_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (2) @(negedge clk);
    checks++;
    if (creq_valid !== 1'b0 || creq_is_write !== 1'b0 || creq_addr !== 64'h0 ||
        creq_size !== 3'd0 || creq_strobe !== 8'h00 || creq_data !== 64'h0) begin
      failures++;
      $display("FAIL reset_creq got v=%b a=%h d=%h want all 0", creq_valid, creq_addr, creq_data);
    end
    checks++;
    if (iresp_addr_ok !== 1'b0 || iresp_data_ok !== 1'b0 || iresp_data !== 32'h0 ||
        dresp_addr_ok !== 1'b0 || dresp_data_ok !== 1'b0 || dresp_data !== 64'h0) begin
      failures++;
      $display("FAIL reset_resp got i=%b d=%b want 0", iresp_data_ok, dresp_data_ok);
    end
    checks++;
    if (int'(dut.starve_cnt) != 0) begin
      failures++;
      $display("FAIL reset_starve got %0d want 0", dut.starve_cnt);
    end
    tick();
    reset = 1'b0;
    cresp_ready = 1'b0;
    cresp_data = 64'h0;
  endtask

  task automatic test_single_fetch();
    int i0;
    i0 = i_done;
    tick();
    ireq_valid = 1'b1;
    ireq_addr  = 64'h8000_0004;
    exp_q.push_back(mk_i(64'h8000_0004, 64'h1111_2222_3333_4444));
    @(negedge clk);
    checks++;
    if (creq_valid !== 1'b0) begin
      failures++;
      $display("FAIL fetch_n0 got creq_valid=%b want 0", creq_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (creq_valid !== 1'b1 || creq_size !== 3'd2 || creq_is_write !== 1'b0 || iresp_data_ok !== 1'b0) begin
      failures++;
      $display("FAIL fetch_n1 got v=%b s=%0d w=%b ok=%b want 1 2 0 0", creq_valid, creq_size, creq_is_write, iresp_data_ok);
    end
    tick();
    cresp_ready = 1'b1;
    cresp_data  = 64'h1111_2222_3333_4444;
    @(negedge clk);
    tick();
    cresp_ready = 1'b0;
    ireq_valid  = 1'b0;
    @(negedge clk);
    checks++;
    if (creq_valid !== 1'b0) begin
      failures++;
      $display("FAIL fetch_idle got creq_valid=%b want 0", creq_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (creq_valid !== 1'b0 || i_done != i0 + 1) begin
      failures++;
      $display("FAIL fetch_once got v=%b n=%0d want v=0 n=%0d", creq_valid, i_done - i0, 1);
    end
  endtask

  task automatic test_single_store();
    int d0;
    d0 = d_done;
    tick();
    dreq_valid  = 1'b1;
    dreq_addr   = 64'h8000_0010;
    dreq_size   = 3'd2;
    dreq_strobe = 8'h0F;
    dreq_data   = 64'h0000_0000_DEAD_BEEF;
    exp_q.push_back(mk_d(64'h8000_0010, 3'd2, 8'h0F, 64'h0000_0000_DEAD_BEEF, 64'h0123_4567_89AB_CDEF));
    @(negedge clk);
    tick();
    cresp_ready = 1'b1;
    cresp_data  = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    checks++;
    if (creq_is_write !== 1'b1 || creq_strobe !== 8'h0F || creq_data !== 64'h0000_0000_DEAD_BEEF ||
        dresp_data_ok !== 1'b1) begin
      failures++;
      $display("FAIL store_req got w=%b st=%h d=%h ok=%b want 1 0f deadbeef 1",
               creq_is_write, creq_strobe, creq_data, dresp_data_ok);
    end
    checks++;
    if (iresp_addr_ok !== 1'b0 || iresp_data_ok !== 1'b0 || iresp_data !== 32'h0) begin
      failures++;
      $display("FAIL store_iquiet got ok=%b data=%h want 0", iresp_data_ok, iresp_data);
    end
    tick();
    cresp_ready = 1'b0;
    dreq_valid  = 1'b0;
    dreq_strobe = 8'h00;
    @(negedge clk);
    checks++;
    if (creq_valid !== 1'b0 || d_done != d0 + 1) begin
      failures++;
      $display("FAIL store_done got v=%b n=%0d want 0 1", creq_valid, d_done - d0);
    end
  endtask

  task automatic test_simultaneous();
    logic [63:0] rsp;
    rsp = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    cresp_ready = 1'b1;
    cresp_data  = rsp;
    ireq_valid  = 1'b1;
    ireq_addr   = 64'h8000_0020;
    dreq_valid  = 1'b1;
    dreq_addr   = 64'h8000_0400;
    dreq_size   = 3'd3;
    dreq_strobe = 8'h00;
    dreq_data   = 64'h0;
    exp_q.push_back(mk_d(64'h8000_0400, 3'd3, 8'h00, 64'h0, rsp));
    exp_q.push_back(mk_i(64'h8000_0020, rsp));
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++;
    if (creq_valid !== 1'b1 || dresp_data_ok !== 1'b1 || int'(dut.starve_cnt) != 1) begin
      failures++;
      $display("FAIL simul_dfirst got v=%b d_ok=%b cnt=%0d want 1 1 1", creq_valid, dresp_data_ok, dut.starve_cnt);
    end
    tick();
    dreq_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (creq_valid !== 1'b0) begin
      failures++;
      $display("FAIL simul_gap got creq_valid=%b want 0", creq_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (creq_valid !== 1'b1 || iresp_data_ok !== 1'b1 || int'(dut.starve_cnt) != 0) begin
      failures++;
      $display("FAIL simul_isecond got v=%b i_ok=%b cnt=%0d want 1 1 0", creq_valid, iresp_data_ok, dut.starve_cnt);
    end
    tick();
    ireq_valid  = 1'b0;
    cresp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_starvation();
    int exp_cnt[6] = '{1, 2, 0, 1, 2, 0};
    bit is_i[6]    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [63:0] rsp;
    int grants;
    int k;
    bit last_d_ok;
    rsp = 64'hCAFE_F00D_1234_5678;
    k = 0;
    for (int i = 0; i < 6; i++) begin
      if (is_i[i]) exp_q.push_back(mk_i(64'h8000_0100, rsp));
      else begin
        exp_q.push_back(mk_d(64'h8000_1000 + 64'(8 * k), 3'd3, 8'hFF, 64'h0123_4567_89AB_CDEF, rsp));
        k++;
      end
    end
    tick();
    cresp_ready = 1'b1;
    cresp_data  = rsp;
    ireq_valid  = 1'b1;
    ireq_addr   = 64'h8000_0100;
    dreq_valid  = 1'b1;
    dreq_addr   = 64'h8000_1000;
    dreq_size   = 3'd3;
    dreq_strobe = 8'hFF;
    dreq_data   = 64'h0123_4567_89AB_CDEF;
    grants = 0;
    last_d_ok = 1'b0;
    for (int c = 0; c < 40 && grants < 6; c++) begin
      if (c > 0) begin
        tick();
        if (last_d_ok) dreq_addr = dreq_addr + 64'd8;
      end
      @(negedge clk);
      if (creq_valid) begin
        checks++;
        if (int'(dut.starve_cnt) != exp_cnt[grants]) begin
          failures++;
          $display("FAIL starve_cnt[%0d] got %0d want %0d", grants, dut.starve_cnt, exp_cnt[grants]);
        end
        grants++;
      end
      last_d_ok = dresp_data_ok;
    end
    checks++;
    if (grants != 6) begin
      failures++;
      $display("FAIL starve_grants got %0d want 6", grants);
    end
    tick();
    ireq_valid  = 1'b0;
    dreq_valid  = 1'b0;
    dreq_strobe = 8'h00;
    cresp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stall_drop();
    int d0;
    d0 = d_done;
    tick();
    dreq_valid  = 1'b1;
    dreq_addr   = 64'h8000_0208;
    dreq_size   = 3'd3;
    dreq_strobe = 8'hF0;
    dreq_data   = 64'h5555_6666_0000_0000;
    exp_q.push_back(mk_d(64'h8000_0208, 3'd3, 8'hF0, 64'h5555_6666_0000_0000, 64'h7777_8888_9999_AAAA));
    @(negedge clk);
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 2) dreq_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (creq_valid !== 1'b1 || creq_addr !== 64'h8000_0208 || creq_is_write !== 1'b1 ||
          creq_strobe !== 8'hF0 || creq_data !== 64'h5555_6666_0000_0000 || dresp_data_ok !== 1'b0) begin
        failures++;
        $display("FAIL stall_c%0d got v=%b a=%h st=%h d=%h ok=%b want held", c,
                 creq_valid, creq_addr, creq_strobe, creq_data, dresp_data_ok);
      end
    end
    tick();
    cresp_ready = 1'b1;
    cresp_data  = 64'h7777_8888_9999_AAAA;
    @(negedge clk);
    tick();
    cresp_ready = 1'b0;
    dreq_strobe = 8'h00;
    @(negedge clk);
    checks++;
    if (creq_valid !== 1'b0 || d_done != d0 + 1) begin
      failures++;
      $display("FAIL stall_done got v=%b n=%0d want 0 1", creq_valid, d_done - d0);
    end
    tick();
    @(negedge clk);
    checks++;
    if (creq_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_regrant got creq_valid=%b want 0", creq_valid);
    end
  endtask

  task automatic test_reset_mid_grant();
    int i0;
    i0 = i_done;
    tick();
    ireq_valid = 1'b1;
    ireq_addr  = 64'h8000_0040;
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++;
    if (creq_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_grant got creq_valid=%b want 1", creq_valid);
    end
    tick();
    reset = 1'b1;
    @(negedge clk);
    tick();
    reset       = 1'b0;
    ireq_valid  = 1'b0;
    cresp_ready = 1'b1;
    cresp_data  = 64'hDEAD_DEAD_BEEF_BEEF;
    @(negedge clk);
    checks++;
    if (creq_valid !== 1'b0 || iresp_data_ok !== 1'b0 || int'(dut.starve_cnt) != 0 || i_done != i0) begin
      failures++;
      $display("FAIL rst_drop got v=%b i_ok=%b cnt=%0d want 0 0 0", creq_valid, iresp_data_ok, dut.starve_cnt);
    end
    tick();
    cresp_ready = 1'b0;
    ireq_valid  = 1'b1;
    ireq_addr   = 64'h8000_004C;
    exp_q.push_back(mk_i(64'h8000_004C, 64'h0BAD_F00D_1357_9BDF));
    @(negedge clk);
    tick();
    @(negedge clk);
    tick();
    cresp_ready = 1'b1;
    cresp_data  = 64'h0BAD_F00D_1357_9BDF;
    @(negedge clk);
    tick();
    cresp_ready = 1'b0;
    ireq_valid  = 1'b0;
    @(negedge clk);
    checks++;
    if (i_done != i0 + 1) begin
      failures++;
      $display("FAIL rst_refetch got %0d want 1", i_done - i0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    ireq_valid  = 1'b0;
    ireq_addr   = '0;
    dreq_valid  = 1'b0;
    dreq_addr   = '0;
    dreq_size   = '0;
    dreq_strobe = '0;
    dreq_data   = '0;
    cresp_ready = 1'b0;
    cresp_data  = '0;
    test_reset();
    test_single_fetch();
    test_single_store();
    test_simultaneous();
    test_starvation();
    test_stall_drop();
    test_reset_mid_grant();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
